// File: rtl/maint_request_gen_if.sv
// rtl/maint_request_gen_if.sv - Signal bundle between the maintenance request stage and its environment.
interface maint_request_gen_if;
    logic       btn_raw;
    logic       op_done;
    logic       ack;
    logic       m;
    logic       overdue;
    logic [7:0] ops_count;
    logic       btn_clean;

    modport master (
        output btn_raw, op_done, ack,
        input  m, overdue, ops_count, btn_clean
    );

    modport slave (
        input  btn_raw, op_done, ack,
        output m, overdue, ops_count, btn_clean
    );
endinterface

// File: rtl/maint_request_gen.sv
// rtl/maint_request_gen.sv - Maintenance request generator: debounced button or usage limit raises m until ack.
module maint_request_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int USE_LIMIT       = 200,
    parameter int TIMEOUT         = 50
) (
    input  logic              clk,
    input  logic              rst,
    maint_request_gen_if.slave bus
);
    localparam logic [7:0]  LP_DEB_M1   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  LP_LIMIT    = 8'(USE_LIMIT);
    localparam logic [7:0]  LP_LIMIT_M1 = 8'(USE_LIMIT - 1);
    localparam logic [15:0] LP_TO_M1    = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_OVERDUE = 2'd2
    } state_t;

    logic [1:0]  r_sync;
    logic [7:0]  r_db_cnt;
    logic        r_btn_clean;
    logic        r_btn_clean_d;
    logic [7:0]  r_ops_count;
    logic        r_auto_trig;
    logic [15:0] r_to_cnt;
    state_t      r_state;
    state_t      w_state_next;
    logic        w_man_trig;
    logic        w_trig;

    // r_sync[1] is the metastability-safe sample; btn_clean only follows it after a stable run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync        <= 2'b00;
            r_db_cnt      <= 8'd0;
            r_btn_clean   <= 1'b0;
            r_btn_clean_d <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], bus.btn_raw};
            r_btn_clean_d <= r_btn_clean;
            if (r_sync[1] != r_btn_clean) begin
                if (r_db_cnt == LP_DEB_M1) begin
                    r_btn_clean <= r_sync[1];
                    r_db_cnt    <= 8'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 8'd1;
                end
            end else begin
                r_db_cnt <= 8'd0;
            end
        end
    end

    assign w_man_trig = r_btn_clean & ~r_btn_clean_d;

    // ack beats op_done; r_auto_trig pulses in the cycle ops_count first reads the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ops_count <= 8'd0;
            r_auto_trig <= 1'b0;
        end else begin
            r_auto_trig <= ~bus.ack & bus.op_done & (r_ops_count == LP_LIMIT_M1);
            if (bus.ack) begin
                r_ops_count <= 8'd0;
            end else if (bus.op_done && (r_ops_count != LP_LIMIT)) begin
                r_ops_count <= r_ops_count + 8'd1;
            end
        end
    end

    assign w_trig = w_man_trig | r_auto_trig;

    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE)) begin
            r_to_cnt <= 16'd0;
        end else if (r_state == ST_PENDING) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trig && !bus.ack) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (bus.ack) begin
                    w_state_next = ST_IDLE;
                end else if (r_to_cnt == LP_TO_M1) begin
                    w_state_next = ST_OVERDUE;
                end
            end
            ST_OVERDUE: begin
                if (bus.ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.m         = (r_state != ST_IDLE);
    assign bus.overdue   = (r_state == ST_OVERDUE);
    assign bus.ops_count = r_ops_count;
    assign bus.btn_clean = r_btn_clean;
endmodule

// File: tb/tb_maint_request_gen.sv
// tb/tb_maint_request_gen.sv - Self-checking bench for maint_request_gen with vector table, directed and random phases.
module tb_maint_request_gen;
    localparam int DEB = 4;
    localparam int LIM = 5;
    localparam int TO  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    maint_request_gen_if bus ();

    maint_request_gen #(.DEBOUNCE_CYCLES(DEB), .USE_LIMIT(LIM), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: request age in cycles since m rose (-1 = no request), debounce as a run length.
    int md_s0 = 0, md_s1 = 0, md_clean = 0, md_clean_d = 0, md_run = 0;
    int md_ops = 0, md_auto = 0, md_age = -1;

    typedef struct {
        bit       rst, btn, od, ack;
        bit       exp_m, exp_ov;
        int       exp_ops;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit b, input bit o, input bit a);
        int trig;
        int ops_new;
        if (r) begin
            md_s0 = 0; md_s1 = 0; md_clean = 0; md_clean_d = 0; md_run = 0;
            md_ops = 0; md_auto = 0; md_age = -1;
        end else begin
            trig = ((md_clean == 1 && md_clean_d == 0) || md_auto == 1) ? 1 : 0;
            if (md_age < 0) md_age = (trig == 1 && !a) ? 0 : -1;
            else if (a) md_age = -1;
            else if (md_age < TO) md_age++;
            ops_new = a ? 0 : ((o && md_ops < LIM) ? md_ops + 1 : md_ops);
            md_auto = (ops_new == LIM && md_ops != LIM) ? 1 : 0;
            md_ops = ops_new;
            md_clean_d = md_clean;
            if (md_s1 != md_clean) begin
                md_run++;
                if (md_run == DEB) begin
                    md_clean = md_s1;
                    md_run = 0;
                end
            end else begin
                md_run = 0;
            end
            md_s1 = md_s0;
            md_s0 = b ? 1 : 0;
        end
    endtask

    task automatic cyc(input bit r, input bit b, input bit o, input bit a);
        logic [10:0] exp;
        rst = r;
        bus.btn_raw = b;
        bus.op_done = o;
        bus.ack = a;
        @(posedge clk);
        #1;
        model_step(r, b, o, a);
        exp = {(md_age >= 0), (md_age >= TO), md_clean[0], md_ops[7:0]};
        chk("model", {bus.m, bus.overdue, bus.btn_clean, bus.ops_count}, exp);
    endtask

    task automatic setv(input int i, input bit r, input bit b, input bit o, input bit a,
                        input bit em, input bit eo, input int eops);
        tbl[i].rst = r; tbl[i].btn = b; tbl[i].od = o; tbl[i].ack = a;
        tbl[i].exp_m = em; tbl[i].exp_ov = eo; tbl[i].exp_ops = eops;
    endtask

    initial begin
        bit rb;
        bus.btn_raw = 1'b0;
        bus.op_done = 1'b0;
        bus.ack = 1'b0;

        //     idx rst btn od ack  m ov ops
        setv( 0, 1, 0, 0, 0,  0, 0, 0);
        setv( 1, 0, 0, 1, 0,  0, 0, 1);
        setv( 2, 0, 0, 1, 0,  0, 0, 2);
        setv( 3, 0, 0, 0, 0,  0, 0, 2);
        setv( 4, 0, 0, 1, 0,  0, 0, 3);
        setv( 5, 0, 0, 1, 0,  0, 0, 4);
        setv( 6, 0, 0, 1, 0,  0, 0, 5);
        setv( 7, 0, 0, 1, 0,  1, 0, 5);
        setv( 8, 0, 0, 0, 0,  1, 0, 5);
        setv( 9, 0, 0, 0, 1,  0, 0, 0);
        setv(10, 0, 0, 1, 1,  0, 0, 0);
        setv(11, 0, 0, 1, 0,  0, 0, 1);
        setv(12, 0, 0, 0, 1,  0, 0, 0);
        setv(13, 0, 0, 1, 0,  0, 0, 1);
        setv(14, 0, 0, 1, 0,  0, 0, 2);
        setv(15, 0, 0, 1, 0,  0, 0, 3);
        setv(16, 0, 0, 1, 0,  0, 0, 4);
        setv(17, 0, 0, 1, 0,  0, 0, 5);
        setv(18, 0, 0, 0, 1,  0, 0, 0);
        setv(19, 0, 0, 0, 0,  0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].rst, tbl[i].btn, tbl[i].od, tbl[i].ack);
            chk($sformatf("vec%0d_m", i), bus.m, tbl[i].exp_m);
            chk($sformatf("vec%0d_ov", i), bus.overdue, tbl[i].exp_ov);
            chk($sformatf("vec%0d_ops", i), bus.ops_count, tbl[i].exp_ops);
        end

        // Bouncing button, then a clean hold.
        cyc(1, 0, 0, 0);
        chk("rst_clean", bus.btn_clean, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, (i % 2 == 0), 0, 0);
            chk("bounce_clean", bus.btn_clean, 0);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("deb_clean_k%0d", k), bus.btn_clean, (k == 6));
            chk($sformatf("deb_m_k%0d", k), bus.m, 0);
        end
        cyc(0, 1, 0, 0);
        chk("deb_m_rise", bus.m, 1);
        cyc(0, 1, 0, 1);
        chk("deb_ack_m", bus.m, 0);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0);
        chk("release_m", bus.m, 0);
        chk("release_clean", bus.btn_clean, 0);

        // Usage limit, then timeout with ack withheld.
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("auto_ops%0d", i), bus.ops_count, i);
            chk($sformatf("auto_m_at%0d", i), bus.m, 0);
        end
        cyc(0, 0, 0, 0);
        chk("to_m_rise", bus.m, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0);
            chk($sformatf("to_ov_k%0d", k), bus.overdue, (k == 10));
            chk($sformatf("to_m_k%0d", k), bus.m, 1);
        end
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 1, 0);
            chk("to_hold", {bus.m, bus.overdue}, 2'b11);
        end
        chk("to_ops_sat", bus.ops_count, 5);
        cyc(0, 0, 0, 1);
        chk("to_ack", {bus.m, bus.overdue}, 2'b00);

        // Manual and automatic triggers in the same cycle give one request.
        cyc(0, 1, 0, 0);
        for (int k = 2; k <= 6; k++) cyc(0, 1, 1, 0);
        chk("sim_clean", bus.btn_clean, 1);
        chk("sim_ops", bus.ops_count, 5);
        chk("sim_m_pre", bus.m, 0);
        cyc(0, 1, 0, 0);
        chk("sim_m", bus.m, 1);
        cyc(0, 1, 0, 1);
        chk("sim_ack", bus.m, 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0);
        chk("sim_single", bus.m, 0);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0);

        // Reset while overdue, then a fresh automatic request.
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        for (int k = 0; k < 11; k++) cyc(0, 0, 0, 0);
        chk("rst_pre_ov", {bus.m, bus.overdue, bus.ops_count}, {2'b11, 8'd5});
        cyc(1, 0, 0, 0);
        chk("rst_mid", {bus.m, bus.overdue, bus.btn_clean, bus.ops_count}, 11'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("re_ops%0d", i), bus.ops_count, i);
            chk($sformatf("re_m%0d", i), bus.m, 0);
        end
        cyc(0, 0, 0, 0);
        chk("re_m_rise", bus.m, 1);

        // Randomized traffic against the reference.
        rb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) rb = ~rb;
            cyc(($urandom_range(0, 599) == 0), rb,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/maint_request_gen.md
Name: maint_request_gen

Overview:
Upstream request stage for the maintenance FSM. It generates the maintenance request input `m` from two sources: a debounced manual pushbutton, and an automatic usage limit reached after USE_LIMIT completed machine operations. The request is held until the FSM acknowledges it through its enable_mant output. An overdue flag is raised if the acknowledge does not arrive within TIMEOUT cycles.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (range 2..255)
USE_LIMIT, 200, completed operations that trigger an automatic request (range 1..255)
TIMEOUT, 50, cycles a request may stay pending before overdue asserts (range 1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
btn_raw  in  1  manual maintenance pushbutton, asynchronous, active-high, may bounce
op_done  in  1  single-cycle pulse per completed machine operation
ack  in  1  acknowledge, driven by the FSM's enable_mant
m  out  1  maintenance request to the FSM, level, held until ack
overdue  out  1  request pending longer than TIMEOUT cycles; sticky until ack
ops_count  out  8  completed operations since the last acknowledged request
btn_clean  out  1  debounced button level

Behaviour:
- One clock: clk. Reset is synchronous and active-high (rst). While rst is high at a clk edge, all registers clear. Reset values: m=0, overdue=0, ops_count=0, btn_clean=0, synchronizer=00, debounce count=0, timeout count=0, state=IDLE. Reset mid-request drops the request with no pulse on m.
- Synchronizer: 2-FF chain on btn_raw.
- Debounce counter:
  - Compares the synchronized sample with btn_clean.
  - If they differ, the counter increments; if they are equal, it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_clean takes the sample and the counter clears.
  - Net latency from a stable btn_raw change to btn_clean = 2 + DEBOUNCE_CYCLES cycles.
- man_trig: a 1-cycle internal pulse on the 0->1 edge of btn_clean.
- Usage counter (ops_count):
  - Increments on op_done; saturates at USE_LIMIT.
  - auto_trig is a 1-cycle internal pulse in the cycle ops_count transitions to USE_LIMIT.
  - ack clears ops_count to 0. ack has priority over op_done in the same cycle, so that op_done is dropped.
- FSM states: IDLE, PENDING, OVERDUE. m = (state != IDLE); overdue = (state == OVERDUE).
  - IDLE: on man_trig or auto_trig (both together count as one request), go to PENDING next cycle and clear the timeout counter. Request latency is 1 cycle from the trigger pulse to m=1. ack in IDLE is ignored, except that it still clears ops_count.
  - PENDING: the timeout counter increments each cycle.
    - ack -> IDLE.
    - Otherwise, the counter reaching TIMEOUT-1 -> OVERDUE. overdue rises exactly TIMEOUT cycles after m rose.
  - OVERDUE: hold until ack -> IDLE.
  - Triggers while PENDING or OVERDUE are absorbed; no queueing.
  - A trigger in the same cycle as ack is discarded; ack wins and the state goes to IDLE.
- m deasserts the cycle after ack is sampled. The FSM's 1-cycle enable_mant pulse is therefore sufficient as ack.
- Unused default state encoding -> IDLE.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, USE_LIMIT=5, TIMEOUT=10.)
- Debounce: btn_raw toggles 1/0 every cycle for 10 cycles, then holds 1 -> btn_clean=0 throughout the bouncing; btn_clean=1 exactly 6 cycles after the final rising edge; m=1 one cycle after that.
- Auto request: 5 op_done pulses, ack tied 0 -> ops_count reads 1..5; m=1 in the cycle after ops_count hits 5. Further op_done pulses leave ops_count at 5.
- Handshake: m=1, pulse ack for 1 cycle -> next cycle m=0, ops_count=0, state IDLE; overdue never set.
- Timeout: raise a request, withhold ack -> overdue=1 exactly 10 cycles after m rose; both stay high for a further 20 cycles; ack -> m=0, overdue=0 next cycle.
- Simultaneous events:
  - Fifth op_done together with a manual trigger -> a single request.
  - ack coincident with op_done -> ops_count=0, not 1.
  - Trigger coincident with ack -> IDLE, m=0.
- Reset mid-operation: in OVERDUE with ops_count=5, assert rst for 1 cycle -> all outputs 0 the next cycle. Then 5 op_done pulses -> a fresh request, with timing as in the Auto request scenario.
